// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and helpers for the multi-word subtract sequencer
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Limb-index width; at least one bit so the counter never collapses to zero width.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - single-limb combinational subtractor with borrow and magnitude compare
module ALU #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  input  logic            i_carry,
  output logic [BITS-1:0] o_out_sub,
  output logic            o_carry,
  output logic [1:0]      o_out_comp
);

  logic [BITS:0] w_full;

  // A negative difference wraps in BITS+1 bits, leaving the top bit set as the borrow.
  assign w_full     = {1'b0, i_a} - {1'b0, i_b} - {{BITS{1'b0}}, i_carry};
  assign o_out_sub  = w_full[BITS-1:0];
  assign o_carry    = w_full[BITS];
  assign o_out_comp = {(i_a > i_b), (i_a == i_b)};

endmodule

// File: rtl/alu_mw_sub_seq.sv
// rtl/alu_mw_sub_seq.sv - wide unsigned subtract/compare, one limb per clock through a single ALU
module alu_mw_sub_seq
  import alu_seq_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int WORDS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [BITS*WORDS-1:0] i_a,
  input  logic [BITS*WORDS-1:0] i_b,
  input  logic                  i_carry_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BITS*WORDS-1:0] o_result,
  output logic                  o_borrow,
  output logic                  o_zero,
  output logic                  o_lt
);

  localparam int IW = idx_w(WORDS);

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_idx;
  logic [BITS*WORDS-1:0] r_a;
  logic [BITS*WORDS-1:0] r_b;
  logic                  r_borrow;
  logic                  r_zero_acc;

  logic [BITS-1:0]       w_a_limb;
  logic [BITS-1:0]       w_b_limb;
  logic [BITS-1:0]       w_diff;
  logic                  w_bout;
  logic [1:0]            w_unused_comp;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_limb_zero;

  assign w_a_limb    = r_a[int'(r_idx)*BITS +: BITS];
  assign w_b_limb    = r_b[int'(r_idx)*BITS +: BITS];
  assign w_accept    = i_start && (r_state == IDLE || r_state == DONE);
  assign w_last      = (r_idx == IW'(WORDS - 1));
  assign w_limb_zero = (w_diff == '0);

  ALU #(.BITS(BITS)) u_alu (
    .i_a        (w_a_limb),
    .i_b        (w_b_limb),
    .i_carry    (r_borrow),
    .o_out_sub  (w_diff),
    .o_carry    (w_bout),
    .o_out_comp (w_unused_comp)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (w_last)  w_next = DONE;
      DONE:    w_next = i_start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign o_busy = (r_state == RUN);
  assign o_done = (r_state == DONE);
  assign o_lt   = o_borrow;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_borrow   <= 1'b0;
      r_zero_acc <= 1'b0;
      o_result   <= '0;
      o_borrow   <= 1'b0;
      o_zero     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a        <= i_a;
        r_b        <= i_b;
        r_borrow   <= i_carry_in;
        r_idx      <= '0;
        r_zero_acc <= 1'b1;
        o_result   <= '0;
        o_borrow   <= 1'b0;
        o_zero     <= 1'b0;
      end else if (r_state == RUN) begin
        o_result[int'(r_idx)*BITS +: BITS] <= w_diff;
        r_borrow   <= w_bout;
        r_zero_acc <= r_zero_acc & w_limb_zero;
        if (w_last) begin
          o_borrow <= w_bout;
          o_zero   <= r_zero_acc & w_limb_zero;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mw_sub_seq.sv
// tb/tb_alu_mw_sub_seq.sv - directed table plus multi-cycle sequences for alu_mw_sub_seq
module tb_alu_mw_sub_seq;

  localparam int BITS  = 8;
  localparam int WORDS = 4;
  localparam int W     = BITS * WORDS;
  localparam int LAT   = WORDS + 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         borrow;
  logic         zero;
  logic         lt;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_res;
    logic         exp_borrow;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[8];

  alu_mw_sub_seq #(.BITS(BITS), .WORDS(WORDS)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_a        (a),
    .i_b        (b),
    .i_carry_in (cin),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_borrow   (borrow),
    .o_zero     (zero),
    .o_lt       (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Waits for o_done; cyc counts the cycle opened by the sampling edge as 1.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tcin, input logic [W-1:0] er, input logic eb, input logic ez);
    int cyc;
    a     = ta;
    b     = tb_;
    cin   = tcin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, " busy"}, 64'(busy), 64'(1));
    wait_done(cyc);
    check({name, " latency"}, 64'(cyc), 64'(LAT));
    check({name, " result"}, 64'(result), 64'(er));
    check({name, " borrow"}, 64'(borrow), 64'(eb));
    check({name, " lt"}, 64'(lt), 64'(eb));
    check({name, " zero"}, 64'(zero), 64'(ez));
    @(posedge clk);
    #1;
    check({name, " done pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int cyc;
    int seen;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0005, 32'h0000_000A, 1'b0, 32'hFFFF_FFFB, 1'b1, 1'b0};
    vecs[2] = '{32'hFEFE_FEFE, 32'hFEFE_FEFE, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h1234_5677, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {busy, done, borrow, zero, lt, result}, 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_res, vecs[i].exp_borrow, vecs[i].exp_zero);
    end

    // Second start during RUN must be ignored.
    a = 32'h10; b = 32'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    a = 32'hDEAD_BEEF; b = 32'h0000_1111; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc);
    check("ignore latency", 64'(cyc), 64'(LAT - 2));
    check("ignore result", 64'(result), 64'h0000_000F);
    check("ignore borrow", 64'(borrow), 64'(0));
    @(posedge clk);
    #1;
    check("ignore no restart", 64'({busy, done}), 64'(0));

    // Reset in the middle of RUN aborts with no done pulse.
    a = 32'h0000_0100; b = 32'h0000_0001; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort outputs", {busy, done, borrow, zero, lt, result}, 64'(0));
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check("abort no done", 64'(seen), 64'(0));
    run_op("post-abort", 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0);

    // Start held high: two operand sets back to back.
    a = 32'h0000_0300; b = 32'h0000_0001; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 32'h0000_0001; b = 32'h0000_0002;
    wait_done(cyc);
    check("b2b first latency", 64'(cyc), 64'(LAT));
    check("b2b first result", 64'(result), 64'h0000_02FF);
    check("b2b first borrow", 64'(borrow), 64'(0));
    @(posedge clk);
    #1;
    wait_done(cyc);
    start = 1'b0;
    check("b2b spacing", 64'(cyc), 64'(LAT));
    check("b2b second result", 64'(result), 64'hFFFF_FFFF);
    check("b2b second borrow", 64'(borrow), 64'(1));
    check("b2b second lt", 64'(lt), 64'(1));
    @(posedge clk);
    #1;
    check("b2b idle", 64'({busy, done}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
